// File: rtl/cyber_press_scheduler_pkg.sv
// Shared definitions for the computer-opponent press scheduler: FSM states,
// input widths and default timing parameters.
package cyber_press_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        PRESS    = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    localparam int DIFF_W           = 9;
    localparam int LFSR_W           = 10;
    localparam int TICK_DIV_DEF     = 8;
    localparam int COOLDOWN_CYC_DEF = 4;
    localparam int CNT_W_DEF        = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cyber_press_scheduler_press_prescaler.sv
// Free-running modulo-TICK_DIV phase counter; tick marks the last phase of
// each sample period. Held at phase 0 while clear_i is high.
module cyber_press_scheduler_press_prescaler
    import cyber_press_scheduler_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              TC_W    = min1_clog2(TICK_DIV);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);

    logic [TC_W-1:0] tick_cnt_q;
    logic [TC_W-1:0] tick_cnt_d;

    assign tick_o = (tick_cnt_q == TC_LAST);

    // Next phase: restart on clear or wrap, otherwise advance.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear_i) begin
            tick_cnt_d = '0;
        end else if (tick_o) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TC_W'(1);
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/cyber_press_scheduler.sv
// Computer-side press sequencer: samples LFSR vs difficulty once per tick,
// emits a one-cycle press, then enforces a cooldown before re-arming.
module cyber_press_scheduler
    import cyber_press_scheduler_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int COOLDOWN_CYC = COOLDOWN_CYC_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              game_over,
    input  logic [DIFF_W-1:0] difficulty,
    input  logic [LFSR_W-1:0] lfsr_q,
    input  logic              clear_count,
    output logic              press,
    output logic              busy,
    output logic [CNT_W-1:0]  press_count
);

    localparam int               CD_W    = min1_clog2(COOLDOWN_CYC);
    localparam logic [CD_W-1:0]  CD_LOAD = (COOLDOWN_CYC > 0) ? CD_W'(COOLDOWN_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic [CD_W-1:0]  cd_cnt_q;
    logic [CD_W-1:0]  cd_cnt_d;
    logic             press_q;
    logic             busy_q;
    logic [CNT_W-1:0] press_count_q;
    logic [CNT_W-1:0] press_count_d;
    logic             go_s;
    logic             hit_s;
    logic             tick_s;

    assign go_s  = enable & ~game_over;
    assign hit_s = ({1'b0, difficulty} > lfsr_q);

    cyber_press_scheduler_press_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (state_q == IDLE),
        .tick_o  (tick_s)
    );

    // Next-state logic; losing go drops to IDLE from anywhere, abandoning any cooldown.
    always_comb begin
        state_d  = state_q;
        cd_cnt_d = cd_cnt_q;
        if (!go_s) begin
            state_d  = IDLE;
            cd_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (tick_s && hit_s) begin
                        state_d = PRESS;
                    end else begin
                        state_d = ARMED;
                    end
                end
                PRESS: begin
                    if (COOLDOWN_CYC == 0) begin
                        state_d = ARMED;
                    end else begin
                        state_d  = COOLDOWN;
                        cd_cnt_d = CD_LOAD;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        state_d  = COOLDOWN;
                        cd_cnt_d = cd_cnt_q - CD_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    cd_cnt_d = '0;
                end
            endcase
        end
    end

    // Saturating press counter; clear wins over a coincident press.
    always_comb begin
        press_count_d = press_count_q;
        if (clear_count) begin
            press_count_d = '0;
        end else if (press_q && (press_count_q != CNT_MAX)) begin
            press_count_d = press_count_q + CNT_W'(1);
        end else begin
            press_count_d = press_count_q;
        end
    end

    // State, cooldown and registered state-decode outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cd_cnt_q      <= '0;
            press_q       <= 1'b0;
            busy_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cd_cnt_q      <= cd_cnt_d;
            press_q       <= (state_d == PRESS);
            busy_q        <= (state_d == PRESS) || (state_d == COOLDOWN);
            press_count_q <= press_count_d;
        end
    end

    assign press       = press_q;
    assign busy        = busy_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_cyber_press_scheduler.sv
// Self-checking bench: TICK_DIV=4, COOLDOWN_CYC=2, with a second CNT_W=2
// instance sharing the same inputs for the saturation scenario.
module tb_cyber_press_scheduler;

    typedef struct {
        logic       press;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       game_over;
    logic [8:0] difficulty;
    logic [9:0] lfsr_q;
    logic       clear_count;
    logic       press;
    logic       busy;
    logic [7:0] press_count;
    logic       press_s;
    logic       busy_s;
    logic [1:0] cnt_s;

    int checks;
    int errors;
    exp_t sb[$];

    cyber_press_scheduler #(.TICK_DIV(4), .COOLDOWN_CYC(2), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .game_over(game_over),
        .difficulty(difficulty), .lfsr_q(lfsr_q), .clear_count(clear_count),
        .press(press), .busy(busy), .press_count(press_count)
    );

    cyber_press_scheduler #(.TICK_DIV(4), .COOLDOWN_CYC(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .game_over(game_over),
        .difficulty(difficulty), .lfsr_q(lfsr_q), .clear_count(clear_count),
        .press(press_s), .busy(busy_s), .press_count(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drop go, clear the counters and leave the DUTs idle at a falling edge.
    task automatic idle_clear();
        enable      = 1'b0;
        game_over   = 1'b0;
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        @(negedge clk);
    endtask

    // Fill the scoreboard with the periodic hit pattern for edges E0..E(n-1).
    task automatic push_periodic(input int n);
        exp_t e;
        int   np;
        np = 0;
        for (int k = 0; k < n; k++) begin
            e.press = (k >= 4) && (k % 4 == 0);
            e.busy  = (k >= 4) && (k % 4 != 3);
            e.cnt   = 8'(np);
            sb.push_back(e);
            if (e.press) np++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; game_over = 1'b0; clear_count = 1'b0;
        difficulty = 9'h100; lfsr_q = 10'h080;
        repeat (2) @(negedge clk);
        checks++;
        if (press !== 1'b0 || busy !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: press=%b busy=%b cnt=%0d, need 0/0/0", press, busy, press_count);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (press !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: press=%b busy=%b, need 0/0", press, busy);
        end
    endtask

    task automatic test_periodic();
        exp_t e;
        idle_clear();
        difficulty = 9'h100; lfsr_q = 10'h080; enable = 1'b1;
        push_periodic(13);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || busy !== e.busy || press_count !== e.cnt) begin
                errors++;
                $display("FAIL periodic E%0d: press=%b busy=%b cnt=%0d, need %b/%b/%0d",
                         k, press, busy, press_count, e.press, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_no_hit();
        int bad;
        for (int p = 0; p < 2; p++) begin
            idle_clear();
            difficulty = (p == 0) ? 9'h080 : 9'h000;
            lfsr_q     = (p == 0) ? 10'h080 : 10'h000;
            enable     = 1'b1;
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (press !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0 || press_count !== 8'd0) begin
                errors++;
                $display("FAIL no_hit_%0d: %0d press cycles, cnt=%0d, need 0/0", p, bad, press_count);
            end
        end
    endtask

    task automatic test_lfsr_alternate();
        exp_t e;
        idle_clear();
        difficulty = 9'h1FF; lfsr_q = 10'h3FF; enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            e.press = (k == 8);
            e.busy  = (k >= 8) && (k <= 10);
            e.cnt   = (k >= 9) ? 8'd1 : 8'd0;
            sb.push_back(e);
        end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || busy !== e.busy || press_count !== e.cnt) begin
                errors++;
                $display("FAIL alternate E%0d: press=%b busy=%b cnt=%0d, need %b/%b/%0d",
                         k, press, busy, press_count, e.press, e.busy, e.cnt);
            end
            if (k == 4) lfsr_q = 10'h1FE;
        end
    endtask

    task automatic test_game_over();
        idle_clear();
        difficulty = 9'h100; lfsr_q = 10'h080; enable = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || press !== 1'b0) begin
            errors++;
            $display("FAIL go_precond E5: press=%b busy=%b, need 0/1", press, busy);
        end
        game_over = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (press !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL game_over +%0d: press=%b busy=%b, need 0/0", j + 1, press, busy);
            end
        end
        game_over = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            checks++;
            if (press !== (r == 4)) begin
                errors++;
                $display("FAIL rearm R%0d: press=%b, need %b", r, press, (r == 4));
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   np;
        idle_clear();
        difficulty = 9'h100; lfsr_q = 10'h080; enable = 1'b1;
        np = 0;
        for (int k = 0; k < 21; k++) begin
            e.press = (k >= 4) && (k % 4 == 0);
            e.busy  = (k >= 4) && (k % 4 != 3);
            e.cnt   = (np > 3) ? 8'd3 : 8'(np);
            sb.push_back(e);
            if (e.press) np++;
        end
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (press_s !== e.press || {6'd0, cnt_s} !== e.cnt) begin
                errors++;
                $display("FAIL saturate E%0d: press=%b cnt=%0d, need %b/%0d",
                         k, press_s, cnt_s, e.press, e.cnt);
            end
        end
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        checks++;
        if (cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL clear_vs_press: cnt=%0d, need 0", cnt_s);
        end
        @(negedge clk);
        checks++;
        if (cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL clear_hold: cnt=%0d, need 0", cnt_s);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        idle_clear();
        difficulty = 9'h100; lfsr_q = 10'h080; enable = 1'b1;
        repeat (9) @(negedge clk);
        checks++;
        if (press !== 1'b1 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL ar_precond E8: press=%b cnt=%0d, need 1/1", press, press_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (press !== 1'b0 || busy !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: press=%b busy=%b cnt=%0d, need 0/0/0", press, busy, press_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        push_periodic(10);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (press !== e.press || busy !== e.busy || press_count !== e.cnt) begin
                errors++;
                $display("FAIL post_reset E%0d: press=%b busy=%b cnt=%0d, need %b/%b/%0d",
                         k, press, busy, press_count, e.press, e.busy, e.cnt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_periodic();
        test_no_hit();
        test_lfsr_alternate();
        test_game_over();
        test_saturate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
